// File: rtl/alu_sequencer_if.sv
// Command, ALU and response bundle between the ALU sequencer and its environment.
// The sequencer takes the slave view; the surrounding system takes the master view.
interface alu_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [15:0]      cmd_a;
  logic [15:0]      cmd_b;
  logic [CNT_W-1:0] cmd_cnt;
  logic [7:0]       inpr;

  logic             alu_en;
  logic [2:0]       alu_op;
  logic [15:0]      alu_d1;
  logic [15:0]      alu_d2;
  logic [7:0]       alu_inpr;
  logic [15:0]      alu_result;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_result;
  logic             rsp_flag;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cnt, inpr,
    input  alu_result, alu_zero, rsp_ready,
    output cmd_ready, alu_en, alu_op, alu_d1, alu_d2, alu_inpr,
    output rsp_valid, rsp_result, rsp_flag, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cnt, inpr,
    output alu_result, alu_zero, rsp_ready,
    input  cmd_ready, alu_en, alu_op, alu_d1, alu_d2, alu_inpr,
    input  rsp_valid, rsp_result, rsp_flag, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one command at a time through an external combinational ALU,
// repeating shifts N times and holding the result until the consumer takes it.
module alu_sequencer #(
  parameter int CNT_W = 4
) (
  input logic         clk,
  input logic         rst,
  alu_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_NUL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [15:0]      w;
  logic [CNT_W-1:0] cnt_q;
  logic             flag_q;

  logic             alu_en_q;
  logic [2:0]       alu_op_q;
  logic [15:0]      alu_d1_q;
  logic [15:0]      alu_d2_q;
  logic [7:0]       alu_inpr_q;

  logic cmd_is_shift;
  logic op_is_shift;
  logic last_iter;

  assign cmd_is_shift = (bus.cmd_op == OP_SLL) || (bus.cmd_op == OP_SRL);
  assign op_is_shift  = (op_q == OP_SLL) || (op_q == OP_SRL);
  assign last_iter    = !op_is_shift || (cnt_q == CNT_W'(1));

  // The ALU-facing registers are only loaded on entry to and during EXEC, so
  // they keep their last values while idle or waiting for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      w          <= '0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      alu_en_q   <= 1'b0;
      alu_op_q   <= '0;
      alu_d1_q   <= '0;
      alu_d2_q   <= '0;
      alu_inpr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q  <= bus.cmd_op;
            w     <= bus.cmd_a;
            cnt_q <= bus.cmd_cnt;
            if (bus.cmd_op == OP_NUL) begin
              flag_q <= (bus.cmd_a == 16'h0000);
              state  <= DONE;
            end else if (cmd_is_shift && (bus.cmd_cnt == '0)) begin
              flag_q <= 1'b0;
              state  <= DONE;
            end else begin
              alu_en_q   <= 1'b1;
              alu_op_q   <= bus.cmd_op;
              alu_d1_q   <= bus.cmd_a;
              alu_d2_q   <= bus.cmd_b;
              alu_inpr_q <= bus.inpr;
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
          w      <= bus.alu_result;
          flag_q <= bus.alu_zero;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (last_iter) begin
            alu_en_q <= 1'b0;
            state    <= DONE;
          end else begin
            alu_d1_q <= bus.alu_result;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.rsp_valid  = (state == DONE);
  assign bus.rsp_result = w;
  assign bus.rsp_flag   = flag_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_d1     = alu_d1_q;
  assign bus.alu_d2     = alu_d2_q;
  assign bus.alu_inpr   = alu_inpr_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU drives the ALU inputs,
// and a reference model derives each command's result, flag and timing.
module tb_alu_sequencer;

  localparam logic [2:0] NUL = 3'd0, ADD = 3'd1, AND = 3'd2, COM = 3'd3;
  localparam logic [2:0] XOR = 3'd4, SLL = 3'd5, SRL = 3'd6, INP = 3'd7;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int          lat;
  int          en_cnt;
  logic [15:0] d1q[$];
  logic [15:0] alu_r;
  logic        alu_z;

  alu_sequencer_if #(.CNT_W(4)) bus ();

  alu_sequencer #(.CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: shifts move one bit and report the bit pushed out,
  // all other operations report whether the result is zero.
  always_comb begin
    alu_r = 16'h0000;
    alu_z = 1'b0;
    case (bus.alu_op)
      ADD: alu_r = bus.alu_d1 + bus.alu_d2;
      AND: alu_r = bus.alu_d1 & bus.alu_d2;
      COM: alu_r = ~bus.alu_d1;
      XOR: alu_r = bus.alu_d1 ^ bus.alu_d2;
      INP: alu_r = {8'h00, bus.alu_inpr};
      default: alu_r = 16'h0000;
    endcase
    if (bus.alu_op == SLL) begin
      alu_r = {bus.alu_d1[14:0], 1'b0};
      alu_z = bus.alu_d1[15];
    end else if (bus.alu_op == SRL) begin
      alu_r = {1'b0, bus.alu_d1[15:1]};
      alu_z = bus.alu_d1[0];
    end else begin
      alu_z = (alu_r == 16'h0000);
    end
  end

  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = alu_z;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: whole-command outcome from plain arithmetic on the operands.
  task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int n, input logic [7:0] ch,
                       output logic [15:0] r, output logic f, output int exp_lat, output int exp_en);
    logic [31:0] wide;
    r = a; f = 1'b0; exp_lat = 2; exp_en = 1;
    case (op)
      NUL: begin r = a; f = (a == 16'h0000); exp_lat = 1; exp_en = 0; end
      ADD: begin wide = 32'(a) + 32'(b); r = wide[15:0]; f = (r == 0); end
      AND: begin r = a & b; f = (r == 0); end
      COM: begin r = ~a; f = (r == 0); end
      XOR: begin r = a ^ b; f = (r == 0); end
      INP: begin r = {8'h00, ch}; f = (r == 0); end
      default: begin
        if (n == 0) begin
          r = a; f = 1'b0; exp_lat = 1; exp_en = 0;
        end else begin
          exp_lat = 1 + n; exp_en = n;
          wide = 32'(a);
          if (op == SLL) begin
            r = 16'((wide << n) & 32'h0000_FFFF);
            f = wide[16 - n];
          end else begin
            r = 16'(wide >> n);
            f = wide[n - 1];
          end
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               input int n, input logic [7:0] ch, input bit consume);
    logic [15:0] er;
    logic        ef;
    int          el;
    int          ee;
    model(op, a, b, n, ch, er, ef, el, ee);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_cnt   = 4'(n);
    bus.inpr      = ch;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    lat    = 1;
    en_cnt = 0;
    d1q.delete();
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.alu_en) begin
        en_cnt++;
        d1q.push_back(bus.alu_d1);
        checkOutput("alu_op", 16'(bus.alu_op), 16'(op));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 16'(lat), 16'(el));
    checkOutput("exec_cycles", 16'(en_cnt), 16'(ee));
    checkOutput("rsp_result", bus.rsp_result, er);
    checkOutput("rsp_flag", 16'(bus.rsp_flag), 16'(ef));
    checkOutput("alu_en_done", 16'(bus.alu_en), 16'd0);
    if (consume) begin
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("cmd_ready_after_rsp", 16'(bus.cmd_ready), 16'd1);
      checkOutput("rsp_valid_after_rsp", 16'(bus.rsp_valid), 16'd0);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] held;
    int          leaked;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 16'h0000;
    bus.cmd_b     = 16'h0000;
    bus.cmd_cnt   = 4'd0;
    bus.inpr      = 8'h00;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", 16'(bus.cmd_ready), 16'd1);
    checkOutput("reset_busy", 16'(bus.busy), 16'd0);
    checkOutput("reset_rsp_valid", 16'(bus.rsp_valid), 16'd0);
    checkOutput("reset_alu_en", 16'(bus.alu_en), 16'd0);
    checkOutput("reset_rsp_result", bus.rsp_result, 16'h0000);
    checkOutput("reset_alu_d1", bus.alu_d1, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed commands");
    applyStimulus(ADD, 16'h000A, 16'h0005, 0, 8'h00, 1'b1);
    applyStimulus(ADD, 16'hFFFF, 16'h0001, 0, 8'h00, 1'b1);
    applyStimulus(INP, 16'h1111, 16'h2222, 0, 8'hAA, 1'b1);
    applyStimulus(SLL, 16'h8001, 16'h0000, 3, 8'h00, 1'b1);
    checkOutput("sll_d1_0", d1q[0], 16'h8001);
    checkOutput("sll_d1_1", d1q[1], 16'h0002);
    checkOutput("sll_d1_2", d1q[2], 16'h0004);
    applyStimulus(SRL, 16'h0003, 16'h0000, 2, 8'h00, 1'b1);
    applyStimulus(SLL, 16'h1234, 16'h0000, 0, 8'h00, 1'b1);
    applyStimulus(NUL, 16'h0000, 16'h5555, 7, 8'h00, 1'b1);
    applyStimulus(NUL, 16'hBEEF, 16'h5555, 7, 8'h00, 1'b1);
    applyStimulus(COM, 16'hFFFF, 16'h0000, 0, 8'h00, 1'b1);
    applyStimulus(SRL, 16'h8000, 16'h0000, 15, 8'h00, 1'b1);

    $display("[TB] randomized commands");
    for (int i = 0; i < 40; i++) begin
      logic [2:0] rop;
      int         rn;
      rop = 3'($urandom_range(0, 7));
      rn  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      applyStimulus(rop, 16'($urandom), 16'($urandom), rn, 8'($urandom), 1'b1);
    end

    $display("[TB] response stall with competing command");
    applyStimulus(XOR, 16'hF0F0, 16'h0FF0, 0, 8'h00, 1'b0);
    held = bus.rsp_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = ADD;
      bus.cmd_a     = 16'h0101;
      bus.cmd_b     = 16'h0202;
      @(posedge clk);
      #1;
      checkOutput("stall_rsp_valid", 16'(bus.rsp_valid), 16'd1);
      checkOutput("stall_rsp_result", bus.rsp_result, 16'hFF00);
      checkOutput("stall_rsp_flag", 16'(bus.rsp_flag), 16'd0);
      checkOutput("stall_cmd_ready", 16'(bus.cmd_ready), 16'd0);
      checkOutput("stall_alu_en", 16'(bus.alu_en), 16'd0);
    end
    checkOutput("stall_held_first", held, 16'hFF00);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("stall_release_cmd_ready", 16'(bus.cmd_ready), 16'd1);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("stall_no_queue_busy", 16'(bus.busy), 16'd0);

    $display("[TB] reset during long shift");
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = SLL;
    bus.cmd_a     = 16'h0001;
    bus.cmd_cnt   = 4'd15;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("pre_reset_alu_en", 16'(bus.alu_en), 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_alu_en", 16'(bus.alu_en), 16'd0);
    checkOutput("mid_reset_rsp_valid", 16'(bus.rsp_valid), 16'd0);
    checkOutput("mid_reset_busy", 16'(bus.busy), 16'd0);
    checkOutput("mid_reset_cmd_ready", 16'(bus.cmd_ready), 16'd1);
    checkOutput("mid_reset_alu_d1", bus.alu_d1, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    leaked = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid || bus.busy) leaked++;
    end
    checkOutput("post_reset_no_response", 16'(leaked), 16'd0);
    checkOutput("post_reset_cmd_ready", 16'(bus.cmd_ready), 16'd1);
    bus.rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
